// File: rtl/dmem_pkg.sv
// dmem_pkg: constants and types shared by the data-memory arbiter slice.
//   DATA_W / ADDR_W : requester data and word-address widths
//   DEPTH / MEM_AW  : memory size in words and memory-side address width
//   port_id_t       : requester identity (MEM stage / loader)
//   state_t         : response FSM states
//   resp_tag_t      : response register contents
package dmem_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 1024;
  localparam int MEM_AW = 10;

  typedef enum logic {
    PORT_MEM  = 1'b0,
    PORT_LOAD = 1'b1
  } port_id_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
    logic     was_read;
    logic     oor;
  } resp_tag_t;

  // Full-width compare: upper address bits must never be dropped.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(DEPTH);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   i_req    : request vector, bit N = port N
//   o_gnt    : one-hot (or zero) grant vector, combinational
// The last-grant pointer resets to 1 so port 0 wins the first contest.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last;
  logic w_win;
  logic w_any;

  // Contest goes to the port not granted last; a lone requester always wins.
  assign w_win = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign w_any = (|i_req) && !rst;
  assign o_gnt = {w_any & w_win, w_any & ~w_win};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|i_req) begin
      r_last <= w_win;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the MEM stage
// (port 0) and the loader/debug port (port 1).
//   clk, rst                  : clock, asynchronous active-high reset
//   i_req/i_we/i_addr/i_wdata : per-port request, held until granted
//   o_gnt                     : per-port accept strobe (combinational)
//   o_rvalid/o_rdata/o_err    : per-port response, one cycle after accept
//   o_mem_*                   : memory access strobe, write enable, address, data
//   i_mem_rdata               : memory read data, one cycle after o_mem_en
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_err0,
  output logic              o_err1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [1:0]        w_gnt;
  logic              w_acc;
  port_id_t          w_port;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;
  logic              w_mem_en;
  logic              w_resp;
  logic [DATA_W-1:0] w_rd;
  state_t            r_state;
  state_t            w_state_next;
  resp_tag_t         r_tag;
  resp_tag_t         w_tag_next;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({i_req1, i_req0}),
    .o_gnt (w_gnt)
  );

  assign o_gnt0 = w_gnt[0];
  assign o_gnt1 = w_gnt[1];

  // Winner's request fields; grant is one-hot so gnt[1] selects the port.
  assign w_acc      = |w_gnt;
  assign w_port     = port_id_t'(w_gnt[1]);
  assign w_we       = w_gnt[1] ? i_we1    : i_we0;
  assign w_addr     = w_gnt[1] ? i_addr1  : i_addr0;
  assign w_wdata    = w_gnt[1] ? i_wdata1 : i_wdata0;
  assign w_in_range = addr_in_range(w_addr);

  // Out-of-range accepts never touch the memory.
  assign w_mem_en    = w_acc && w_in_range;
  assign o_mem_en    = w_mem_en;
  assign o_mem_we    = w_mem_en && w_we;
  assign o_mem_addr  = w_mem_en ? w_addr[MEM_AW-1:0] : '0;
  assign o_mem_wdata = w_mem_en ? w_wdata : '0;

  always_comb begin
    w_tag_next = '0;
    if (w_acc) begin
      w_tag_next.valid    = 1'b1;
      w_tag_next.port     = w_port;
      w_tag_next.was_read = !w_we;
      w_tag_next.oor      = !w_in_range;
    end
  end

  // RESP holds while accepts keep arriving back-to-back.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = w_acc ? S_RESP : S_IDLE;
      S_RESP:  w_state_next = w_acc ? S_RESP : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_next;
      r_tag   <= w_tag_next;
    end
  end

  assign w_resp = (r_state == S_RESP) && r_tag.valid;
  // Only in-range reads carry memory data; write acks and errors return zero.
  assign w_rd   = (r_tag.was_read && !r_tag.oor) ? i_mem_rdata : '0;

  assign o_rvalid0 = w_resp && (r_tag.port == PORT_MEM);
  assign o_rvalid1 = w_resp && (r_tag.port == PORT_LOAD);
  assign o_rdata0  = o_rvalid0 ? w_rd : '0;
  assign o_rdata1  = o_rvalid1 ? w_rd : '0;
  assign o_err0    = o_rvalid0 && r_tag.oor;
  assign o_err1    = o_rvalid1 && r_tag.oor;

endmodule
